// File: rtl/cpu2_pkg.sv
// cpu2_pkg: shared widths, opcode encodings and FSM state encoding for the
// cpu2 accumulator CPU.
package cpu2_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ASHL = 4'b0001;
    localparam logic [3:0] OP_ASHR = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_LDA  = 4'b0101;
    localparam logic [3:0] OP_STA  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_JZ   = 4'b1000;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

endpackage

// File: rtl/cpu2_if.sv
// cpu2_if: memory bus between the CPU (master) and the unified 16x8 memory
// (slave). Memory reads are combinational, writes land on the next clk edge.
interface cpu2_if;
    import cpu2_pkg::*;

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] memoryOut;
    logic [DATA_W-1:0] memoryIn;

    modport master (
        output read,
        output write,
        output address,
        output memoryIn,
        input  memoryOut
    );

    modport slave (
        input  read,
        input  write,
        input  address,
        input  memoryIn,
        output memoryOut
    );

endinterface

// File: rtl/cpu2_alu.sv
// cpu2_alu: combinational datapath. Produces the next accumulator value,
// the value to write back to memory for ASHL/ASHR/STA, and the ACC==0 flag.
module cpu2_alu
    import cpu2_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] mdr,
    output logic [DATA_W-1:0] acc_next,
    output logic [DATA_W-1:0] mem_result,
    output logic              zero
);

    // Accumulator update and memory write-back value selected by opcode
    always_comb begin
        acc_next   = acc;
        mem_result = acc;
        case (op)
            OP_ASHL: mem_result = {mdr[DATA_W-2:0], 1'b0};
            OP_ASHR: mem_result = {mdr[DATA_W-1], mdr[DATA_W-1:1]};
            OP_ADD:  acc_next   = acc + mdr;
            OP_SUB:  acc_next   = acc - mdr;
            OP_LDA:  acc_next   = mdr;
            default: ;
        endcase
    end

    assign zero = (acc == '0);

endmodule

// File: rtl/cpu2_core.sv
// cpu2_core: multi-cycle accumulator CPU, FETCH -> LOAD -> EXEC per instruction.
// Optional feature macro CPU2_HALT_EN: when defined, opcode 1111 parks the CPU
// in a terminal HALT state; when undefined, 1111 executes as a NOP.
module cpu2_core
    import cpu2_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    cpu2_if.master bus
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] acc;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] mem_result;
    logic              zero;
    logic              is_store;

    assign opcode   = ir[DATA_W-1:DATA_W-4];
    assign operand  = ir[ADDR_W-1:0];
    assign is_store = (opcode == OP_ASHL) || (opcode == OP_ASHR) || (opcode == OP_STA);

    cpu2_alu u_alu (
        .op         (opcode),
        .acc        (acc),
        .mdr        (mdr),
        .acc_next   (acc_next),
        .mem_result (mem_result),
        .zero       (zero)
    );

    // Instruction sequencer: register updates for each phase of an instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= '0;
            ir    <= '0;
            mdr   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir    <= bus.memoryOut;
                    pc    <= pc + ADDR_W'(1);
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    mdr   <= bus.memoryOut;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    acc   <= acc_next;
                    state <= S_FETCH;
                    if (opcode == OP_JMP || (opcode == OP_JZ && zero)) begin
                        pc <= operand;
                    end
`ifdef CPU2_HALT_EN
                    if (opcode == OP_HLT) begin
                        state <= S_HALT;
                    end
`endif
                end
                default: state <= state;
            endcase
        end
    end

    // Bus outputs decoded from the current phase; all forced idle during reset
    always_comb begin
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.address  = '0;
        bus.memoryIn = '0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    bus.read    = 1'b1;
                    bus.address = pc;
                end
                S_LOAD: begin
                    bus.read    = 1'b1;
                    bus.address = operand;
                end
                S_EXEC: begin
                    bus.address = operand;
                    if (is_store) begin
                        bus.write    = 1'b1;
                        bus.memoryIn = mem_result;
                    end
                end
                default: bus.address = pc;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu2_core.sv
// tb_cpu2_core: directed tests for cpu2_core against a 16x8 bench memory.
// Follows CPU2_HALT_EN the same way the design does.
module tb_cpu2_core;
    import cpu2_pkg::*;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic load_en = 1'b0;
    logic [7:0] mem   [16];
    logic [7:0] image [16];
    int checks = 0;
    int errors = 0;

    cpu2_if bus ();

    cpu2_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bench memory: bulk image load during reset, otherwise CPU writes
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= image[i];
        end else if (bus.write) begin
            mem[bus.address] <= bus.memoryIn;
        end
    end

    assign bus.memoryOut = mem[bus.address];

    task automatic clear_image;
        for (int i = 0; i < 16; i++) image[i] = 8'h00;
    endtask

    task automatic do_reset;
        reset   = 1'b1;
        load_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0;
        reset   = 1'b0;
        #1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        clear_image();
        image[0] = 8'h16;
        reset    = 1'b1;
        load_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.address !== 4'h0 || bus.memoryIn !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got r=%0b w=%0b a=%h d=%h expected all zero",
                     bus.read, bus.write, bus.address, bus.memoryIn);
        end
        load_en = 1'b0;
        reset   = 1'b0;
        #1;
        checks++;
        if (bus.read !== 1'b1 || bus.write !== 1'b0 || bus.address !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch: got r=%0b w=%0b a=%h expected r=1 w=0 a=0",
                     bus.read, bus.write, bus.address);
        end
        checks++;
        if (dut.pc !== 4'h0 || dut.acc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_regs: got pc=%h acc=%h expected pc=0 acc=00", dut.pc, dut.acc);
        end
    endtask

    task automatic test_ashl;
        clear_image();
        image[0] = 8'h16;
        image[1] = 8'h56;
        image[2] = 8'h54;
        image[6] = 8'h03;
        do_reset();
        run_cycles(2);
        checks++;
        if (bus.write !== 1'b1 || bus.address !== 4'h6 || bus.memoryIn !== 8'h06) begin
            errors++;
            $display("[TB] FAIL ashl_exec_bus: got w=%0b a=%h d=%h expected w=1 a=6 d=06",
                     bus.write, bus.address, bus.memoryIn);
        end
        run_cycles(1);
        checks++;
        if (mem[6] !== 8'h06) begin
            errors++;
            $display("[TB] FAIL ashl_result: got %h expected 06", mem[6]);
        end
        run_cycles(3);
        checks++;
        if (dut.acc !== 8'h06) begin
            errors++;
            $display("[TB] FAIL ashl_lda: got acc=%h expected 06", dut.acc);
        end
        run_cycles(3);
        checks++;
        if (mem[6] !== 8'h06 || dut.acc !== 8'h00) begin
            errors++;
            $display("[TB] FAIL ashl_after9: got m6=%h acc=%h expected m6=06 acc=00", mem[6], dut.acc);
        end
    endtask

    task automatic test_ashr_sign;
        clear_image();
        image[0] = 8'h27;
        image[7] = 8'h84;
        do_reset();
        run_cycles(3);
        checks++;
        if (mem[7] !== 8'hC2) begin
            errors++;
            $display("[TB] FAIL ashr_sign: got %h expected c2", mem[7]);
        end
    endtask

    task automatic test_alu;
        clear_image();
        image[0]  = 8'h5A;
        image[1]  = 8'h3B;
        image[2]  = 8'h6C;
        image[10] = 8'h05;
        image[11] = 8'h07;
        do_reset();
        run_cycles(9);
        checks++;
        if (mem[12] !== 8'h0C) begin
            errors++;
            $display("[TB] FAIL alu_add_store: got %h expected 0c", mem[12]);
        end
    endtask

    task automatic test_sub_wrap;
        clear_image();
        image[0]  = 8'h4A;
        image[1]  = 8'h6B;
        image[10] = 8'h01;
        do_reset();
        run_cycles(6);
        checks++;
        if (mem[11] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL sub_wrap: got %h expected ff", mem[11]);
        end
    endtask

    task automatic test_jump_wrap;
        clear_image();
        image[0]  = 8'h7F;
        image[15] = 8'h00;
        do_reset();
        run_cycles(3);
        checks++;
        if (dut.pc !== 4'hF || bus.address !== 4'hF || bus.read !== 1'b1) begin
            errors++;
            $display("[TB] FAIL jmp_target: got pc=%h a=%h r=%0b expected pc=f a=f r=1",
                     dut.pc, bus.address, bus.read);
        end
        run_cycles(1);
        checks++;
        if (dut.pc !== 4'h0) begin
            errors++;
            $display("[TB] FAIL pc_wrap: got %h expected 0", dut.pc);
        end
        run_cycles(1);
        checks++;
        if (bus.write !== 1'b0 || bus.read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nop_exec_bus: got w=%0b r=%0b expected w=0 r=0", bus.write, bus.read);
        end
        run_cycles(1);
        checks++;
        if (bus.address !== 4'h0 || bus.read !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wrap_fetch: got a=%h r=%0b expected a=0 r=1", bus.address, bus.read);
        end
    endtask

    task automatic test_jz;
        clear_image();
        image[0] = 8'h85;
        do_reset();
        run_cycles(3);
        checks++;
        if (dut.pc !== 4'h5 || bus.address !== 4'h5) begin
            errors++;
            $display("[TB] FAIL jz_taken: got pc=%h a=%h expected 5", dut.pc, bus.address);
        end
        clear_image();
        image[0]  = 8'h5E;
        image[1]  = 8'h88;
        image[14] = 8'h01;
        do_reset();
        run_cycles(6);
        checks++;
        if (dut.pc !== 4'h2 || bus.address !== 4'h2 || dut.acc !== 8'h01) begin
            errors++;
            $display("[TB] FAIL jz_not_taken: got pc=%h a=%h acc=%h expected pc=2 a=2 acc=01",
                     dut.pc, bus.address, dut.acc);
        end
    endtask

    task automatic test_halt;
        clear_image();
        image[0] = 8'hF0;
        do_reset();
        run_cycles(3);
`ifdef CPU2_HALT_EN
        checks++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.address !== 4'h1 || dut.pc !== 4'h1) begin
            errors++;
            $display("[TB] FAIL halt_enter: got r=%0b w=%0b a=%h pc=%h expected r=0 w=0 a=1 pc=1",
                     bus.read, bus.write, bus.address, dut.pc);
        end
        run_cycles(5);
        checks++;
        if (bus.read !== 1'b0 || bus.write !== 1'b0 || dut.pc !== 4'h1) begin
            errors++;
            $display("[TB] FAIL halt_stay: got r=%0b w=%0b pc=%h expected r=0 w=0 pc=1",
                     bus.read, bus.write, dut.pc);
        end
`else
        checks++;
        if (bus.read !== 1'b1 || bus.address !== 4'h1) begin
            errors++;
            $display("[TB] FAIL hlt_as_nop: got r=%0b a=%h expected r=1 a=1", bus.read, bus.address);
        end
        run_cycles(3);
        checks++;
        if (bus.read !== 1'b1 || bus.address !== 4'h2) begin
            errors++;
            $display("[TB] FAIL hlt_continue: got r=%0b a=%h expected r=1 a=2", bus.read, bus.address);
        end
`endif
    endtask

    task automatic test_reset_mid_exec;
        clear_image();
        image[0] = 8'h16;
        image[6] = 8'h03;
        do_reset();
        run_cycles(2);
        checks++;
        if (bus.write !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_exec_pending: got w=%0b expected 1", bus.write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.write !== 1'b0 || bus.read !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_bus: got w=%0b r=%0b expected 0", bus.write, bus.read);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (mem[6] !== 8'h03) begin
            errors++;
            $display("[TB] FAIL mid_reset_nowrite: got %h expected 03", mem[6]);
        end
        checks++;
        if (bus.address !== 4'h0 || bus.read !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_refetch: got a=%h r=%0b expected a=0 r=1", bus.address, bus.read);
        end
    endtask

    // Scenario sequence
    initial begin
        clear_image();
        $display("[TB] cpu2_core directed tests");
        test_reset();
        test_ashl();
        test_ashr_sign();
        test_alu();
        test_sub_wrap();
        test_jump_wrap();
        test_jz();
        test_halt();
        test_reset_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
